// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
//   Shared type for the mem_ctrl request/response sequencer.
//   state_t enumerates the controller FSM:
//     IDLE    - waiting for a client request
//     WR      - write strobe on the RAM port
//     RD_REQ  - read strobe on the RAM port
//     RD_WAIT - RAM output register loading
//     RD_CAP  - RAM douta valid, captured on the next edge
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RD_CAP  = 3'd4
  } state_t;

endpackage

// File: rtl/xilinx_single_port_ram_read_first.sv
// xilinx_single_port_ram_read_first
//   Single-port block RAM, read-first, with an output register
//   (2-cycle read latency). Contents are not initialised or cleared.
//   Ports:
//     clka   - clock
//     addra  - word address
//     dina   - write data
//     wea    - write enable (qualified by ena)
//     ena    - port enable; read or write happens only when high
//     rsta   - synchronous reset of the output register only
//     regcea - output register clock enable
//     douta  - registered read data
module xilinx_single_port_ram_read_first #(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_DEPTH = 8,
  localparam int ADDR_W   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                 clka,
  input  logic [ADDR_W-1:0]    addra,
  input  logic [RAM_WIDTH-1:0] dina,
  input  logic                 wea,
  input  logic                 ena,
  input  logic                 rsta,
  input  logic                 regcea,
  output logic [RAM_WIDTH-1:0] douta
);

  logic [RAM_WIDTH-1:0] bram [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data;

  // Read-first: the array value before the write is returned.
  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) begin
        bram[addra] <= dina;
      end
      ram_data <= bram[addra];
    end
  end

  // Output register: second cycle of read latency.
  always_ff @(posedge clka) begin
    if (rsta) begin
      douta <= '0;
    end else if (regcea) begin
      douta <= ram_data;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl
//   Sequencer between a single-request client and a read-first block RAM
//   with 2-cycle read latency. One request is in flight at a time; requests
//   arriving while busy are dropped. Write wins over a simultaneous read.
//   Ports:
//     clk_i, rst_i        - clock, asynchronous active-high reset
//     cntlr_rd_i          - read request pulse, with cntlr_raddr_i
//     cntlr_rd_data_o     - read data, held until the next read completes
//     cntlr_rd_valid_o    - one-cycle pulse when cntlr_rd_data_o updates
//     cntlr_wr_i          - write request pulse, with cntlr_waddr_i/_wr_data_i
//     cntlr_wr_done_o     - one-cycle pulse once the write is committed
//     mem_rd_o, mem_wr_o  - RAM read strobe / write enable (ena = rd | wr)
//     mem_addr_o          - RAM address, holds its value while idle
//     mem_wr_data_o       - RAM write data, holds its value while idle
//     mem_rd_data_i       - RAM douta
//   Every output is a register; the combinational block computes their
//   next values together with the next state.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_DEPTH = 8,
  localparam int ADDR_W   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cntlr_rd_i,
  input  logic [ADDR_W-1:0]    cntlr_raddr_i,
  output logic [RAM_WIDTH-1:0] cntlr_rd_data_o,
  output logic                 cntlr_rd_valid_o,
  input  logic                 cntlr_wr_i,
  input  logic [ADDR_W-1:0]    cntlr_waddr_i,
  input  logic [RAM_WIDTH-1:0] cntlr_wr_data_i,
  output logic                 cntlr_wr_done_o,
  output logic                 mem_rd_o,
  output logic                 mem_wr_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [RAM_WIDTH-1:0] mem_wr_data_o,
  input  logic [RAM_WIDTH-1:0] mem_rd_data_i
);

  state_t               state, state_nxt;
  logic                 mem_rd_nxt, mem_wr_nxt;
  logic [ADDR_W-1:0]    mem_addr_nxt;
  logic [RAM_WIDTH-1:0] mem_wr_data_nxt;
  logic [RAM_WIDTH-1:0] rd_data_nxt;
  logic                 rd_valid_nxt, wr_done_nxt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobes are set on the edge that accepts the request, so they are high
  // exactly while the FSM sits in WR / RD_REQ.
  always_comb begin
    state_nxt       = state;
    mem_rd_nxt      = 1'b0;
    mem_wr_nxt      = 1'b0;
    mem_addr_nxt    = mem_addr_o;
    mem_wr_data_nxt = mem_wr_data_o;
    rd_data_nxt     = cntlr_rd_data_o;
    rd_valid_nxt    = 1'b0;
    wr_done_nxt     = 1'b0;

    unique case (state)
      IDLE: begin
        if (cntlr_wr_i) begin
          mem_addr_nxt    = cntlr_waddr_i;
          mem_wr_data_nxt = cntlr_wr_data_i;
          mem_wr_nxt      = 1'b1;
          state_nxt       = WR;
        end else if (cntlr_rd_i) begin
          mem_addr_nxt = cntlr_raddr_i;
          mem_rd_nxt   = 1'b1;
          state_nxt    = RD_REQ;
        end
      end
      WR: begin
        // RAM commits on this edge.
        wr_done_nxt = 1'b1;
        state_nxt   = IDLE;
      end
      RD_REQ: begin
        // RAM array is read on this edge.
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        // RAM output register loads on this edge.
        state_nxt = RD_CAP;
      end
      RD_CAP: begin
        rd_data_nxt  = mem_rd_data_i;
        rd_valid_nxt = 1'b1;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_rd_o         <= 1'b0;
      mem_wr_o         <= 1'b0;
      mem_addr_o       <= '0;
      mem_wr_data_o    <= '0;
      cntlr_rd_data_o  <= '0;
      cntlr_rd_valid_o <= 1'b0;
      cntlr_wr_done_o  <= 1'b0;
    end else begin
      mem_rd_o         <= mem_rd_nxt;
      mem_wr_o         <= mem_wr_nxt;
      mem_addr_o       <= mem_addr_nxt;
      mem_wr_data_o    <= mem_wr_data_nxt;
      cntlr_rd_data_o  <= rd_data_nxt;
      cntlr_rd_valid_o <= rd_valid_nxt;
      cntlr_wr_done_o  <= wr_done_nxt;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl
//   Directed bench for mem_ctrl with the read-first RAM model alongside it.
//   Inputs are driven at the falling edge; outputs are sampled at the falling
//   edge, so sample k of an operation lies in cycle E(k-1)..E(k).
module tb_mem_ctrl;

  localparam int W = 8;
  localparam int D = 8;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd_req = 1'b0;
  logic [A-1:0] raddr = '0;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         wr_req = 1'b0;
  logic [A-1:0] waddr = '0;
  logic [W-1:0] wdata = '0;
  logic         wr_done;
  logic         mem_rd, mem_wr;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cntlr_rd_i       (rd_req),
    .cntlr_raddr_i    (raddr),
    .cntlr_rd_data_o  (rd_data),
    .cntlr_rd_valid_o (rd_valid),
    .cntlr_wr_i       (wr_req),
    .cntlr_waddr_i    (waddr),
    .cntlr_wr_data_i  (wdata),
    .cntlr_wr_done_o  (wr_done),
    .mem_rd_o         (mem_rd),
    .mem_wr_o         (mem_wr),
    .mem_addr_o       (mem_addr),
    .mem_wr_data_o    (mem_wdata),
    .mem_rd_data_i    (mem_rdata)
  );

  xilinx_single_port_ram_read_first #(.RAM_WIDTH(W), .RAM_DEPTH(D)) ram (
    .clka   (clk),
    .addra  (mem_addr),
    .dina   (mem_wdata),
    .wea    (mem_wr),
    .ena    (mem_rd | mem_wr),
    .rsta   (rst),
    .regcea (1'b1),
    .douta  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observations of one operation window.
  int           n_wr, k_wr, n_rd, k_rd, n_both, n_done, k_done, n_valid, k_valid;
  logic [A-1:0] wr_addr_seen, rd_addr_seen;
  logic [W-1:0] wr_data_seen, valid_data, held_data;

  // Launch a request (rd/wr as given) and watch 10 cycles. When inj_k > 0,
  // an extra read request to address 7 is driven from sample inj_k so that
  // it is presented at edge E(inj_k).
  task automatic run_op(input logic rd, input logic wr, input logic [A-1:0] ra,
                        input logic [A-1:0] wa, input logic [W-1:0] wd, input int inj_k);
    n_wr = 0; k_wr = 0; n_rd = 0; k_rd = 0; n_both = 0;
    n_done = 0; k_done = 0; n_valid = 0; k_valid = 0;
    wr_addr_seen = '0; rd_addr_seen = '0; wr_data_seen = '0; valid_data = '0;
    @(negedge clk);
    rd_req = rd; wr_req = wr; raddr = ra; waddr = wa; wdata = wd;
    @(posedge clk);
    #1 rd_req = 1'b0; wr_req = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_wr) begin
        n_wr++; wr_addr_seen = mem_addr; wr_data_seen = mem_wdata;
        if (k_wr == 0) k_wr = k;
      end
      if (mem_rd) begin
        n_rd++; rd_addr_seen = mem_addr;
        if (k_rd == 0) k_rd = k;
      end
      if (mem_rd && mem_wr) n_both++;
      if (wr_done) begin
        n_done++;
        if (k_done == 0) k_done = k;
      end
      if (rd_valid) begin
        n_valid++; valid_data = rd_data;
        if (k_valid == 0) k_valid = k;
      end
      rd_req = (k == inj_k);
      if (k == inj_k) raddr = 3'd7;
    end
    held_data = rd_data;
  endtask

  task automatic check_write(input string tag, input logic [A-1:0] a, input logic [W-1:0] d);
    chk({tag, ".wr_cycles"}, n_wr, 1);
    chk({tag, ".wr_at"}, k_wr, 1);
    chk({tag, ".wr_addr"}, wr_addr_seen, a);
    chk({tag, ".wr_data"}, wr_data_seen, d);
    chk({tag, ".done_cnt"}, n_done, 1);
    chk({tag, ".done_at"}, k_done, 2);
    chk({tag, ".rd_strobes"}, n_rd, 0);
    chk({tag, ".valid_cnt"}, n_valid, 0);
  endtask

  task automatic check_read(input string tag, input logic [A-1:0] a, input logic [W-1:0] d);
    chk({tag, ".rd_cycles"}, n_rd, 1);
    chk({tag, ".rd_at"}, k_rd, 1);
    chk({tag, ".rd_addr"}, rd_addr_seen, a);
    chk({tag, ".valid_cnt"}, n_valid, 1);
    chk({tag, ".valid_at"}, k_valid, 4);
    chk({tag, ".data"}, valid_data, d);
    chk({tag, ".held"}, held_data, d);
    chk({tag, ".wr_strobes"}, n_wr, 0);
    chk({tag, ".done_cnt"}, n_done, 0);
    chk({tag, ".both_high"}, n_both, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".mem_rd"}, mem_rd, 0);
    chk({tag, ".mem_wr"}, mem_wr, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".rd_data"}, rd_data, 0);
    chk({tag, ".rd_valid"}, rd_valid, 0);
    chk({tag, ".wr_done"}, wr_done, 0);
  endtask

  initial begin
    int quiet_valid;

    // Reset state.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("post_reset_idle");

    // Sequential fill and readback: 0xAD + i at address i.
    for (int i = 0; i < 8; i++) begin
      run_op(1'b0, 1'b1, '0, A'(i), W'(8'hAD + i), 0);
      check_write($sformatf("seq_wr%0d", i), A'(i), W'(8'hAD + i));
    end
    for (int i = 0; i < 8; i++) begin
      run_op(1'b1, 1'b0, A'(i), '0, '0, 0);
      check_read($sformatf("seq_rd%0d", i), A'(i), W'(8'hAD + i));
    end

    // Single write 0x5A to address 3, then read it back.
    run_op(1'b0, 1'b1, '0, 3'd3, 8'h5A, 0);
    check_write("single_wr", 3'd3, 8'h5A);
    run_op(1'b1, 1'b0, 3'd3, '0, '0, 0);
    check_read("single_rd", 3'd3, 8'h5A);

    // Walking ones.
    for (int i = 0; i < 8; i++) begin
      run_op(1'b0, 1'b1, '0, A'(i), W'(8'h01 << i), 0);
      check_write($sformatf("walk_wr%0d", i), A'(i), W'(8'h01 << i));
      run_op(1'b1, 1'b0, A'(i), '0, '0, 0);
      check_read($sformatf("walk_rd%0d", i), A'(i), W'(8'h01 << i));
    end

    // Simultaneous read and write: write wins, read is not performed.
    run_op(1'b1, 1'b1, 3'd2, 3'd2, 8'hC3, 0);
    check_write("both_req", 3'd2, 8'hC3);
    run_op(1'b1, 1'b0, 3'd2, '0, '0, 0);
    check_read("both_readback", 3'd2, 8'hC3);

    // Second read request presented while the first is in RD_WAIT is dropped.
    run_op(1'b1, 1'b0, 3'd3, '0, '0, 2);
    check_read("drop_rd", 3'd3, 8'h08);

    // Reset during RD_WAIT of a read to address 5 (holds 0x20).
    @(negedge clk);
    rd_req = 1'b1; raddr = 3'd5;
    @(posedge clk);
    #1 rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    quiet_valid = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rd_valid) quiet_valid++;
    end
    chk("mid_reset.no_valid", quiet_valid, 0);
    chk("mid_reset.data_cleared", rd_data, 0);
    run_op(1'b1, 1'b0, 3'd5, '0, '0, 0);
    check_read("after_reset_rd", 3'd5, 8'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
